// File: rtl/acl_txbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : acl_txbuf_ctrl
// Brief    : Ping-pong ACL TX payload buffer controller for the active link.
//            Decides new / retransmit / flush per TX ACL slot from the ARQN
//            of the previous RX slot. It drives buffer selects, SEQN toggle
//            requests and buffer-release interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module acl_txbuf_ctrl #(
    parameter int MAX_RETX = 8,
    parameter int LEN_W    = 10
) (
    input  logic             clk_6M,
    input  logic             rstz,
    input  logic             conns_new,
    input  logic             ms_tslot_p,
    input  logic             pk_encode,
    input  logic             tx_acl_slot,
    input  logic             rx_arqn,
    input  logic             rx_hdr_ok,
    input  logic             regi_wrdone_p,
    input  logic [LEN_W-1:0] regi_buflen,
    input  logic             regi_flushcmd_p,
    output logic             txbuf_rdsel,
    output logic             txbuf_wrsel,
    output logic [LEN_W-1:0] txbuf_len,
    output logic             send_data,
    output logic             send_null,
    output logic             chgbufcmd_p,
    output logic             buf_free_p,
    output logic             wr_overrun_p,
    output logic [7:0]       retx_cnt
);

    // SEND = first transmission of a payload issued, WAIT = retransmitting,
    // FLUSH = zero-length continuation sent in place of the stale payload.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t           r_state,      w_state_nxt;
    logic             r_rdsel,      w_rdsel_nxt;
    logic             r_full_a,     w_full_a_nxt;
    logic             r_full_b,     w_full_b_nxt;
    logic [LEN_W-1:0] r_len_a,      w_len_a_nxt;
    logic [LEN_W-1:0] r_len_b,      w_len_b_nxt;
    logic             r_flush_req,  w_flush_req_nxt;
    logic [7:0]       r_retx,       w_retx_nxt;
    logic             r_send_data,  w_send_data_nxt;
    logic             r_send_null,  w_send_null_nxt;
    logic [LEN_W-1:0] r_txlen,      w_txlen_nxt;
    logic             r_chg,        w_chg_nxt;
    logic             r_free,       w_free_nxt;
    logic             r_ovr,        w_ovr_nxt;

    logic             w_decide;
    logic             w_ack;
    logic             w_full_rd;
    logic             w_full_wr;
    logic [LEN_W-1:0] w_len_rd;
    logic [LEN_W-1:0] w_len_wr;
    logic             w_flush_any;
    logic [7:0]       w_retx_inc;
    logic             w_retx_limit;

    // Only a TX slot carrying ACL for this link is a decision point.
    assign w_decide     = ms_tslot_p & pk_encode & tx_acl_slot;
    // A lost or corrupted RX header is treated as a NAK.
    assign w_ack        = rx_arqn & rx_hdr_ok;
    assign w_full_rd    = r_rdsel ? r_full_b : r_full_a;
    assign w_full_wr    = r_rdsel ? r_full_a : r_full_b;
    assign w_len_rd     = r_rdsel ? r_len_b  : r_len_a;
    assign w_len_wr     = r_rdsel ? r_len_a  : r_len_b;
    // A flush command arriving in the decision cycle itself is honoured too.
    assign w_flush_any  = r_flush_req | regi_flushcmd_p;
    assign w_retx_inc   = (r_retx == 8'hFF) ? 8'hFF : (r_retx + 8'd1);
    assign w_retx_limit = (MAX_RETX != 0) && (int'(w_retx_inc) == MAX_RETX);

    // Next-state and registered-output decode: write path every cycle, slot decision on D only.
    always_comb begin
        w_state_nxt     = r_state;
        w_rdsel_nxt     = r_rdsel;
        w_full_a_nxt    = r_full_a;
        w_full_b_nxt    = r_full_b;
        w_len_a_nxt     = r_len_a;
        w_len_b_nxt     = r_len_b;
        w_flush_req_nxt = w_flush_any;
        w_retx_nxt      = r_retx;
        w_send_data_nxt = r_send_data;
        w_send_null_nxt = r_send_null;
        w_txlen_nxt     = r_txlen;
        w_chg_nxt       = 1'b0;
        w_free_nxt      = 1'b0;
        w_ovr_nxt       = 1'b0;

        // MCU write completion always targets the buffer not being read.
        if (regi_wrdone_p) begin
            if (w_full_wr) begin
                w_ovr_nxt = 1'b1;
            end else if (r_rdsel) begin
                w_full_a_nxt = 1'b1;
                w_len_a_nxt  = regi_buflen;
            end else begin
                w_full_b_nxt = 1'b1;
                w_len_b_nxt  = regi_buflen;
            end
        end

        if (w_decide) begin
            w_flush_req_nxt = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_full_rd) begin
                        w_state_nxt     = ST_SEND;
                        w_send_data_nxt = 1'b1;
                        w_send_null_nxt = 1'b0;
                        w_txlen_nxt     = w_len_rd;
                        w_retx_nxt      = 8'd0;
                    end else if (w_full_wr) begin
                        w_rdsel_nxt     = ~r_rdsel;
                        w_chg_nxt       = 1'b1;
                        w_state_nxt     = ST_SEND;
                        w_send_data_nxt = 1'b1;
                        w_send_null_nxt = 1'b0;
                        w_txlen_nxt     = w_len_wr;
                        w_retx_nxt      = 8'd0;
                    end else begin
                        w_send_data_nxt = 1'b0;
                        w_send_null_nxt = 1'b1;
                        w_txlen_nxt     = '0;
                    end
                end
                default: begin
                    if (w_ack) begin
                        // Acknowledged: release the read buffer; an ack beats a pending flush.
                        w_free_nxt = 1'b1;
                        if (r_rdsel) begin
                            w_full_b_nxt = 1'b0;
                        end else begin
                            w_full_a_nxt = 1'b0;
                        end
                        if (w_full_wr) begin
                            w_rdsel_nxt     = ~r_rdsel;
                            w_chg_nxt       = 1'b1;
                            w_state_nxt     = ST_SEND;
                            w_send_data_nxt = 1'b1;
                            w_send_null_nxt = 1'b0;
                            w_txlen_nxt     = w_len_wr;
                            w_retx_nxt      = 8'd0;
                        end else begin
                            w_state_nxt     = ST_IDLE;
                            w_send_data_nxt = 1'b0;
                            w_send_null_nxt = 1'b1;
                            w_txlen_nxt     = '0;
                        end
                    end else begin
                        // NAK: resend with the same SEQN, either the payload or a flush.
                        w_retx_nxt      = w_retx_inc;
                        w_send_data_nxt = 1'b1;
                        w_send_null_nxt = 1'b0;
                        if ((r_state == ST_FLUSH) || w_flush_any || w_retx_limit) begin
                            w_state_nxt = ST_FLUSH;
                            w_txlen_nxt = '0;
                        end else begin
                            w_state_nxt = ST_WAIT;
                            w_txlen_nxt = w_len_rd;
                        end
                    end
                end
            endcase
        end
    end

    // State and output registers; conns_new wipes everything without signalling a release.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_state     <= ST_IDLE;
            r_rdsel     <= 1'b0;
            r_full_a    <= 1'b0;
            r_full_b    <= 1'b0;
            r_len_a     <= '0;
            r_len_b     <= '0;
            r_flush_req <= 1'b0;
            r_retx      <= 8'd0;
            r_send_data <= 1'b0;
            r_send_null <= 1'b1;
            r_txlen     <= '0;
            r_chg       <= 1'b0;
            r_free      <= 1'b0;
            r_ovr       <= 1'b0;
        end else if (conns_new) begin
            r_state     <= ST_IDLE;
            r_rdsel     <= 1'b0;
            r_full_a    <= 1'b0;
            r_full_b    <= 1'b0;
            r_len_a     <= '0;
            r_len_b     <= '0;
            r_flush_req <= 1'b0;
            r_retx      <= 8'd0;
            r_send_data <= 1'b0;
            r_send_null <= 1'b1;
            r_txlen     <= '0;
            r_chg       <= 1'b0;
            r_free      <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rdsel     <= w_rdsel_nxt;
            r_full_a    <= w_full_a_nxt;
            r_full_b    <= w_full_b_nxt;
            r_len_a     <= w_len_a_nxt;
            r_len_b     <= w_len_b_nxt;
            r_flush_req <= w_flush_req_nxt;
            r_retx      <= w_retx_nxt;
            r_send_data <= w_send_data_nxt;
            r_send_null <= w_send_null_nxt;
            r_txlen     <= w_txlen_nxt;
            r_chg       <= w_chg_nxt;
            r_free      <= w_free_nxt;
            r_ovr       <= w_ovr_nxt;
        end
    end

    assign txbuf_rdsel  = r_rdsel;
    assign txbuf_wrsel  = ~r_rdsel;
    assign txbuf_len    = r_txlen;
    assign send_data    = r_send_data;
    assign send_null    = r_send_null;
    assign chgbufcmd_p  = r_chg;
    assign buf_free_p   = r_free;
    assign wr_overrun_p = r_ovr;
    assign retx_cnt     = r_retx;

endmodule
`default_nettype wire

// File: tb/tb_acl_txbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_acl_txbuf_ctrl
// Brief    : Self-checking bench for acl_txbuf_ctrl: directed vector table,
//            hand-written corner sequences and a random run against a
//            payload-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acl_txbuf_ctrl;

    localparam int LEN_W    = 10;
    localparam int MAX_RETX = 8;
    localparam int OW       = LEN_W + 15;

    logic             clk_6M = 1'b0;
    logic             rstz = 1'b0;
    logic             conns_new = 1'b0;
    logic             ms_tslot_p = 1'b0;
    logic             pk_encode = 1'b0;
    logic             tx_acl_slot = 1'b0;
    logic             rx_arqn = 1'b0;
    logic             rx_hdr_ok = 1'b0;
    logic             regi_wrdone_p = 1'b0;
    logic [LEN_W-1:0] regi_buflen = '0;
    logic             regi_flushcmd_p = 1'b0;
    logic             txbuf_rdsel;
    logic             txbuf_wrsel;
    logic [LEN_W-1:0] txbuf_len;
    logic             send_data;
    logic             send_null;
    logic             chgbufcmd_p;
    logic             buf_free_p;
    logic             wr_overrun_p;
    logic [7:0]       retx_cnt;

    acl_txbuf_ctrl #(
        .MAX_RETX (MAX_RETX),
        .LEN_W    (LEN_W)
    ) dut (
        .clk_6M          (clk_6M),
        .rstz            (rstz),
        .conns_new       (conns_new),
        .ms_tslot_p      (ms_tslot_p),
        .pk_encode       (pk_encode),
        .tx_acl_slot     (tx_acl_slot),
        .rx_arqn         (rx_arqn),
        .rx_hdr_ok       (rx_hdr_ok),
        .regi_wrdone_p   (regi_wrdone_p),
        .regi_buflen     (regi_buflen),
        .regi_flushcmd_p (regi_flushcmd_p),
        .txbuf_rdsel     (txbuf_rdsel),
        .txbuf_wrsel     (txbuf_wrsel),
        .txbuf_len       (txbuf_len),
        .send_data       (send_data),
        .send_null       (send_null),
        .chgbufcmd_p     (chgbufcmd_p),
        .buf_free_p      (buf_free_p),
        .wr_overrun_p    (wr_overrun_p),
        .retx_cnt        (retx_cnt)
    );

    always #83 clk_6M = ~clk_6M;

    int n_cmp  = 0;
    int n_fail = 0;

    // One row = one clock of stimulus plus the outputs required after that edge.
    // slot: 0 none, 1 TX ACL slot (decision), 2 RX slot, 3 TX slot not for ACL
    typedef struct {
        int cn; int slot; int arqn; int hdr; int wr; int len; int fl;
        int sd; int sn; int tl; int rd; int chg; int fr; int ov; int rx;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [OW-1:0] pk(input int sd, input int sn, input int tl, input int rd,
                                         input int chg, input int fr, input int ov, input int rx);
        logic b_rd;
        b_rd = 1'(rd);
        return {1'(sd), 1'(sn), LEN_W'(tl), b_rd, ~b_rd, 1'(chg), 1'(fr), 1'(ov), 8'(rx)};
    endfunction

    function automatic string fmt(input logic [OW-1:0] v);
        return $sformatf("sd=%0b sn=%0b len=%0d rd=%0b wr=%0b chg=%0b free=%0b ovr=%0b retx=%0d",
                         v[OW-1], v[OW-2], v[13 +: LEN_W], v[12], v[11], v[10], v[9], v[8], v[7:0]);
    endfunction

    task automatic check(input string nm, input int idx, input logic [OW-1:0] exp);
        logic [OW-1:0] act;
        act = {send_data, send_null, txbuf_len, txbuf_rdsel, txbuf_wrsel,
               chgbufcmd_p, buf_free_p, wr_overrun_p, retx_cnt};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: actual %s, required %s", nm, idx, fmt(act), fmt(exp));
        end
    endtask

    // Apply one cycle of inputs at the falling edge; return just after the next rising edge.
    task automatic drive(input int cn, input int slot, input int arqn, input int hdr,
                         input int wr, input int len, input int fl);
        @(negedge clk_6M);
        conns_new       = 1'(cn);
        ms_tslot_p      = (slot != 0);
        pk_encode       = (slot == 1) || (slot == 3);
        tx_acl_slot     = (slot == 1) || (slot == 2);
        rx_arqn         = 1'(arqn);
        rx_hdr_ok       = 1'(hdr);
        regi_wrdone_p   = 1'(wr);
        regi_buflen     = LEN_W'(len);
        regi_flushcmd_p = 1'(fl);
        @(posedge clk_6M);
        #1;
    endtask

    // ---------------- reference model: payloads as an ordered queue ----------------
    int q[$];
    int m_rd, m_active, m_flushing, m_freq, m_retx;
    int e_sd, e_sn, e_tl, e_chg, e_fr, e_ov;

    task automatic model_reset();
        q.delete();
        m_rd = 0; m_active = 0; m_flushing = 0; m_freq = 0; m_retx = 0;
        e_sd = 0; e_sn = 1; e_tl = 0; e_chg = 0; e_fr = 0; e_ov = 0;
    endtask

    task automatic model_step(input int cn, input int d, input int ack,
                              input int wr, input int len, input int fl);
        int ovr;
        int fq;
        if (cn != 0) begin
            model_reset();
            return;
        end
        e_chg = 0; e_fr = 0; e_ov = 0;
        // The write buffer is full when it already holds the queued-but-not-sending payload.
        ovr = ((wr != 0) && (q.size() == (m_active != 0 ? 2 : 1))) ? 1 : 0;
        fq  = ((m_freq != 0) || (fl != 0)) ? 1 : 0;
        m_freq = fq;
        if (d != 0) begin
            m_freq = 0;
            if (m_active == 0) begin
                if (q.size() > 0) begin
                    m_rd = 1 - m_rd; e_chg = 1; m_active = 1; m_flushing = 0; m_retx = 0;
                    e_sd = 1; e_sn = 0; e_tl = q[0];
                end else begin
                    e_sd = 0; e_sn = 1; e_tl = 0;
                end
            end else if (ack != 0) begin
                void'(q.pop_front());
                e_fr = 1; m_flushing = 0;
                if (q.size() > 0) begin
                    m_rd = 1 - m_rd; e_chg = 1; m_retx = 0;
                    e_sd = 1; e_sn = 0; e_tl = q[0];
                end else begin
                    m_active = 0;
                    e_sd = 0; e_sn = 1; e_tl = 0;
                end
            end else begin
                m_retx = (m_retx < 255) ? m_retx + 1 : 255;
                if ((fq != 0) || (MAX_RETX != 0 && m_retx == MAX_RETX)) m_flushing = 1;
                e_sd = 1; e_sn = 0;
                e_tl = (m_flushing != 0) ? 0 : q[0];
            end
        end
        if ((wr != 0) && (ovr == 0)) q.push_back(len);
        e_ov = ovr;
    endtask

    initial begin
        // ---------------- directed vector table ----------------
        //              cn sl aq hd wr len  fl   sd sn tl  rd ch fr ov rx
        vecs.push_back('{0, 0, 0, 0, 0, 0,   0,   0, 1, 0,   0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 27,  0,   0, 1, 0,   0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0,   0,   1, 0, 27,  1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0,   0,   1, 0, 27,  1, 0, 0, 0, 0});
        vecs.push_back('{0, 2, 1, 1, 0, 0,   0,   1, 0, 27,  1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 100, 0,   1, 0, 27,  1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 1, 0, 0,   0,   1, 0, 100, 0, 1, 1, 0, 0});
        vecs.push_back('{0, 3, 1, 1, 0, 0,   0,   1, 0, 100, 0, 0, 0, 0, 0});
        for (int k = 1; k <= 7; k++)
            vecs.push_back('{0, 1, 1, 0, 0, 0, 0,  1, 0, 100, 0, 0, 0, 0, k});
        vecs.push_back('{0, 1, 1, 0, 0, 0,   0,   1, 0, 0,   0, 0, 0, 0, 8});
        vecs.push_back('{0, 1, 1, 1, 0, 0,   0,   0, 1, 0,   0, 0, 1, 0, 8});
        vecs.push_back('{0, 0, 0, 0, 1, 5,   0,   0, 1, 0,   0, 0, 0, 0, 8});
        vecs.push_back('{0, 1, 1, 1, 0, 0,   0,   1, 0, 5,   1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0,   1,   1, 0, 5,   1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 1, 0, 0,   0,   0, 1, 0,   1, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 7,   0,   0, 1, 0,   1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0,   0,   1, 0, 7,   0, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 0,   0,   1, 0, 7,   0, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 9,   0,   1, 0, 7,   0, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 11,  0,   1, 0, 7,   0, 0, 0, 1, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 0,   0,   1, 0, 7,   0, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 1, 1, 0, 0,   0,   1, 0, 9,   1, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 13,  0,   1, 0, 9,   1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0,   0,   1, 0, 9,   1, 0, 0, 0, 1});
        vecs.push_back('{1, 0, 0, 0, 0, 0,   0,   0, 1, 0,   0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 1, 0, 0,   0,   0, 1, 0,   0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 3,   0,   0, 1, 0,   0, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0,   0,   1, 0, 3,   1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0,   1,   1, 0, 3,   1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0,   0,   1, 0, 0,   1, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 0, 0,   0,   1, 0, 0,   1, 0, 0, 0, 2});
        vecs.push_back('{0, 1, 1, 1, 0, 0,   0,   0, 1, 0,   1, 0, 1, 0, 2});
        vecs.push_back('{0, 0, 0, 0, 1, 0,   0,   0, 1, 0,   1, 0, 0, 0, 2});
        vecs.push_back('{0, 1, 0, 0, 0, 0,   0,   1, 0, 0,   0, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 1, 0, 0,   0,   0, 1, 0,   0, 0, 1, 0, 0});

        // ---------------- reset ----------------
        repeat (3) @(posedge clk_6M);
        #1;
        check("reset_state", 0, pk(0, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk_6M);
        rstz = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].cn, vecs[i].slot, vecs[i].arqn, vecs[i].hdr,
                  vecs[i].wr, vecs[i].len, vecs[i].fl);
            check("vector", i, pk(vecs[i].sd, vecs[i].sn, vecs[i].tl, vecs[i].rd,
                                  vecs[i].chg, vecs[i].fr, vecs[i].ov, vecs[i].rx));
        end

        // ---------------- hand sequence: flush request while idle is discarded ----------------
        drive(0, 0, 0, 0, 0, 0, 1);
        check("idle_flush_hold", 0, pk(0, 1, 0, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, 1, 50, 0);
        check("idle_flush_fill", 1, pk(0, 1, 0, 0, 0, 0, 0, 0));
        drive(0, 1, 0, 0, 0, 0, 0);
        check("idle_flush_start", 2, pk(1, 0, 50, 1, 1, 0, 0, 0));
        drive(0, 1, 0, 0, 0, 0, 0);
        check("idle_flush_gone", 3, pk(1, 0, 50, 1, 0, 0, 0, 1));

        // ---------------- hand sequence: conns_new beats a simultaneous write ----------------
        drive(1, 0, 0, 0, 1, 60, 0);
        check("cn_with_write", 0, pk(0, 1, 0, 0, 0, 0, 0, 0));
        drive(0, 1, 1, 1, 0, 0, 0);
        check("cn_write_dropped", 1, pk(0, 1, 0, 0, 0, 0, 0, 0));

        // ---------------- random run against the queue model ----------------
        drive(1, 0, 0, 0, 0, 0, 0);
        model_reset();
        check("rand_start", 0, pk(e_sd, e_sn, e_tl, m_rd, e_chg, e_fr, e_ov, m_retx));
        for (int c = 0; c < 4000; c++) begin
            int r_cn, r_slot, r_arqn, r_hdr, r_wr, r_len, r_fl, r_d;
            bit noisy;
            noisy  = ((c / 500) % 2) == 1;
            r_cn   = ($urandom % 400 == 0) ? 1 : 0;
            r_slot = int'($urandom % 6);
            if (r_slot > 3) r_slot = 0;
            r_arqn = noisy ? (($urandom % 8 == 0) ? 1 : 0) : (($urandom % 4 != 0) ? 1 : 0);
            r_hdr  = ($urandom % 8 != 0) ? 1 : 0;
            r_wr   = ($urandom % 5 == 0) ? 1 : 0;
            r_len  = int'($urandom_range(0, 1021));
            r_fl   = ($urandom % 40 == 0) ? 1 : 0;
            r_d    = (r_slot == 1) ? 1 : 0;
            drive(r_cn, r_slot, r_arqn, r_hdr, r_wr, r_len, r_fl);
            model_step(r_cn, r_d, r_arqn & r_hdr, r_wr, r_len, r_fl);
            check("random", c, pk(e_sd, e_sn, e_tl, m_rd, e_chg, e_fr, e_ov, m_retx));
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
